// File: rtl/spfp_to_fixed_converter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spfp_pkg
// Purpose  : Shared single-precision float constants and types: field
//            widths, exponent bias, the packed operand layout and the
//            converter state encoding.
// Revision : 1.0  initial release
// ============================================================================
package spfp_pkg;

    localparam int        EXP_W    = 8;
    localparam int        MANT_W   = 23;
    localparam int        EXP_BIAS = 127;
    localparam logic [7:0] EXP_INF = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } spfp_t;

    // Converter FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/spfp_to_fixed_converter_if.sv
`default_nettype none
// ============================================================================
// Module   : spfp_to_fixed_converter_if
// Purpose  : Valid/ready bundle for the float-to-fixed converter.
//            Input side : in_valid, in_ready, in_data[31:0]
//            Output side: out_valid, out_ready, out_data[OUT_W-1:0],
//                         out_sat, out_exception
//            master = producer/consumer environment, slave = converter.
// Revision : 1.0  initial release
// ============================================================================
interface spfp_to_fixed_converter_if #(
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_exception;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_exception
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_exception
    );
endinterface
`default_nettype wire

// File: rtl/spfp_to_fixed_converter_unpack.sv
`default_nettype none
// ============================================================================
// Module   : spfp_unpack
// Purpose  : Combinational field split of a single-precision operand.
//            Denormals are flushed: any zero exponent yields a zero
//            significand and o_is_zero=1.
// Ports    : i_word     packed operand
//            o_sign     sign bit
//            o_exp      biased exponent
//            o_sig      24-bit significand with hidden bit
//            o_is_zero  exponent is zero (zero or denormal)
//            o_is_inf   exponent all ones, mantissa zero
//            o_is_nan   exponent all ones, mantissa non-zero
// Revision : 1.0  initial release
// ============================================================================
module spfp_unpack
    import spfp_pkg::*;
(
    input  spfp_t             i_word,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W:0]   o_sig,
    output logic              o_is_zero,
    output logic              o_is_inf,
    output logic              o_is_nan
);
    logic w_exp_max;
    logic w_mant_nz;

    assign w_exp_max = (i_word.exp == EXP_INF);
    assign w_mant_nz = (i_word.mant != '0);

    assign o_sign    = i_word.sign;
    assign o_exp     = i_word.exp;
    assign o_is_zero = (i_word.exp == '0);
    assign o_sig     = o_is_zero ? '0 : {1'b1, i_word.mant};
    assign o_is_inf  = w_exp_max & ~w_mant_nz;
    assign o_is_nan  = w_exp_max &  w_mant_nz;
endmodule
`default_nettype wire

// File: rtl/spfp_to_fixed_converter.sv
`default_nettype none
// ============================================================================
// Module   : spfp_to_fixed_converter
// Purpose  : Converts a single-precision float into signed two's-complement
//            Q(OUT_W-FRAC_W).FRAC_W using an iterative multi-bit shifter,
//            with saturation and Inf/NaN flagging.
// Ports    : clk  clock, rising edge
//            rst  synchronous reset, active-high
//            bus  slave side of spfp_to_fixed_converter_if
// Revision : 1.0  initial release
// ============================================================================
module spfp_to_fixed_converter #(
    parameter int OUT_W      = 16,
    parameter int FRAC_W     = 8,
    parameter int SHIFT_STEP = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    spfp_to_fixed_converter_if.slave   bus
);
    import spfp_pkg::*;

    localparam int MAG_W = MANT_W + 1 + OUT_W;

    // value = sig * 2^s, s = exp - (bias + mant bits) + frac bits
    localparam logic signed [9:0] c_s_offset = 10'(EXP_BIAS + MANT_W - FRAC_W);
    localparam logic signed [9:0] c_s_sat    = 10'(OUT_W - 1);
    localparam logic signed [9:0] c_s_zero   = -10'(MANT_W + 1);

    localparam logic [MAG_W-1:0] c_lim_pos = {{(MAG_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [MAG_W-1:0] c_lim_neg = {{(MAG_W-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] c_max_pos = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_max_neg = {1'b1, {(OUT_W-1){1'b0}}};

    state_t           r_state;
    spfp_t            r_word;
    logic             r_sign;
    logic             r_left;
    logic             r_exc;
    logic [9:0]       r_rem;
    logic [MAG_W-1:0] r_mag;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_sat;
    logic             r_out_exc;

    logic              w_sign;
    logic [EXP_W-1:0]  w_exp;
    logic [MANT_W:0]   w_sig;
    logic              w_is_zero;
    logic              w_is_inf;
    logic              w_is_nan;
    logic signed [9:0] w_s;
    logic [9:0]        w_abs_s;
    logic [3:0]        w_step;
    logic [9:0]        w_rem_next;
    logic [MAG_W-1:0]  w_mag_shifted;
    logic [MAG_W-1:0]  w_limit;
    logic              w_over;
    logic [OUT_W-1:0]  w_mag_lo;
    logic [OUT_W-1:0]  w_result;

    spfp_unpack u_unpack (
        .i_word    (r_word),
        .o_sign    (w_sign),
        .o_exp     (w_exp),
        .o_sig     (w_sig),
        .o_is_zero (w_is_zero),
        .o_is_inf  (w_is_inf),
        .o_is_nan  (w_is_nan)
    );

    assign w_s     = $signed({2'b00, w_exp}) - c_s_offset;
    assign w_abs_s = w_s[9] ? $unsigned(-w_s) : $unsigned(w_s);

    // Per-cycle shift distance: min(SHIFT_STEP, remaining)
    always_comb begin
        w_step = r_rem[3:0];
        if (r_rem > 10'(SHIFT_STEP)) begin
            w_step = 4'(SHIFT_STEP);
        end
    end

    assign w_rem_next    = r_rem - 10'(w_step);
    assign w_mag_shifted = r_left ? (r_mag << w_step) : (r_mag >> w_step);

    // Negative range reaches one step further than positive
    assign w_limit  = r_sign ? c_lim_neg : c_lim_pos;
    assign w_over   = (r_mag > w_limit);
    assign w_mag_lo = r_mag[OUT_W-1:0];
    assign w_result = w_over ? (r_sign ? c_max_neg : c_max_pos)
                             : (r_sign ? -w_mag_lo : w_mag_lo);

    // Fast paths preload the magnitude so the common clamp stage yields the
    // right answer: all-ones forces saturation, zero forces a zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_word      <= '0;
            r_sign      <= 1'b0;
            r_left      <= 1'b0;
            r_exc       <= 1'b0;
            r_rem       <= '0;
            r_mag       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_exc   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_word  <= bus.in_data;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_sign  <= w_sign;
                    r_exc   <= w_is_inf | w_is_nan;
                    r_left  <= ~w_s[9];
                    r_rem   <= '0;
                    r_state <= ST_DONE;
                    if (w_is_nan || w_is_zero || (w_s <= c_s_zero)) begin
                        r_mag <= '0;
                    end else if (w_is_inf || (w_s >= c_s_sat)) begin
                        r_mag <= '1;
                    end else begin
                        r_mag <= {{OUT_W{1'b0}}, w_sig};
                        r_rem <= w_abs_s;
                        if (w_abs_s != '0) begin
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_mag <= w_mag_shifted;
                    r_rem <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle registers the clamped result; outputs
                    // then hold until the downstream handshake.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_result;
                        r_out_sat   <= w_over;
                        r_out_exc   <= r_exc;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (r_state == ST_IDLE) & ~rst;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_data      = r_out_data;
    assign bus.out_sat       = r_out_sat;
    assign bus.out_exception = r_out_exc;

endmodule
`default_nettype wire

// File: tb/tb_spfp_to_fixed_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spfp_to_fixed_converter
// Purpose  : Directed self-checking bench for spfp_to_fixed_converter
//            (OUT_W=16, FRAC_W=8, SHIFT_STEP=4) with a result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_spfp_to_fixed_converter;

    logic clk = 1'b0;
    logic rst;

    spfp_to_fixed_converter_if #(.OUT_W(16)) bus ();

    spfp_to_fixed_converter #(
        .OUT_W      (16),
        .FRAC_W     (8),
        .SHIFT_STEP (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        logic        sat_care;
        logic        exc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and wait (bounded) for the accepting edge.
    task automatic accept(input logic [31:0] w);
        int n;
        n = 0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic check_pop(input string tag, input int lat);
        exp_t e;
        chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, e.data});
        if (e.sat_care) chk({tag, "_sat"}, {31'd0, bus.out_sat}, {31'd0, e.sat});
        chk({tag, "_exc"}, {31'd0, bus.out_exception}, {31'd0, e.exc});
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic convert(input string tag, input logic [31:0] w, input logic [15:0] d,
                           input logic sat, input logic sat_care, input logic exc, input int lat);
        int l;
        exp_t e;
        e = '{d, sat, sat_care, exc, lat};
        sb.push_back(e);
        accept(w);
        wait_out(l);
        check_pop(tag, l);
        handshake(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   l;
        exp_t e;
        bit   seen;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) tick();

        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {16'd0, bus.out_data}, 32'd0);
        chk("rst_out_sat",   {31'd0, bus.out_sat}, 32'd0);
        chk("rst_out_exc",   {31'd0, bus.out_exception}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // tag, word, data, sat, sat_care, exc, latency
        convert("one",      32'h3F800000, 16'h0100, 1'b0, 1'b1, 1'b0, 6);
        convert("m2p5",     32'hC0200000, 16'hFD80, 1'b0, 1'b1, 1'b0, 6);
        convert("p2m8",     32'h3B800000, 16'h0001, 1'b0, 1'b1, 1'b0, 8);
        convert("p2m9",     32'h3B000000, 16'h0000, 1'b0, 1'b1, 1'b0, 2);
        convert("p1000",    32'h447A0000, 16'h7FFF, 1'b1, 1'b1, 1'b0, 4);
        convert("m1000",    32'hC47A0000, 16'h8000, 1'b1, 1'b1, 1'b0, 4);
        convert("m128",     32'hC3000000, 16'h8000, 1'b0, 1'b1, 1'b0, 4);
        convert("pinf",     32'h7F800000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 2);
        convert("minf",     32'hFF800000, 16'h8000, 1'b0, 1'b0, 1'b1, 2);
        convert("nan",      32'h7FC00000, 16'h0000, 1'b0, 1'b0, 1'b1, 2);
        convert("denorm",   32'h00000001, 16'h0000, 1'b0, 1'b1, 1'b0, 2);
        convert("negzero",  32'h80000000, 16'h0000, 1'b0, 1'b1, 1'b0, 2);

        // Backpressure: hold out_ready low with a new request pending.
        e = '{16'h0100, 1'b0, 1'b1, 1'b0, 6};
        sb.push_back(e);
        accept(32'h3F800000);
        wait_out(l);
        check_pop("bp", l);
        bus.in_data  = 32'hC0200000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_data",  {16'd0, bus.out_data}, 32'h0100);
            chk("bp_hold_sat",   {31'd0, bus.out_sat}, 32'd0);
            chk("bp_hold_exc",   {31'd0, bus.out_exception}, 32'd0);
            chk("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("bp_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_ready_rise", {31'd0, bus.in_ready}, 32'd1);
        e = '{16'hFD80, 1'b0, 1'b1, 1'b0, 6};
        sb.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_accepted", {31'd0, bus.in_ready}, 32'd0);
        wait_out(l);
        check_pop("bp_next", l);
        handshake("bp_next");

        // Reset in the middle of a shift sequence.
        accept(32'h3F800000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_data",  {16'd0, bus.out_data}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_output", {31'd0, seen}, 32'd0);
        convert("after_rst", 32'h3F800000, 16'h0100, 1'b0, 1'b1, 1'b0, 6);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
